// File: rtl/axis_buf_pkg.sv
// Shared constants and helpers for the AXI-Stream register FIFO.
// Holds default widths/depths and a constant-foldable clog2.
package axis_buf_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_buf_mem.sv
// Storage array for axis_reg_fifo: DEPTH x (DATA_W+1), {last, data}.
// Ports: clk_i, we_i/waddr_i/wdata_i write port, raddr_i/rdata_o read.
module axis_buf_mem
  import axis_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DATA_W:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DATA_W:0] rdata_o
);

  // Contents are deliberately not reset.
  logic [DATA_W:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Address comes from the read-pointer flop in the parent.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_reg_fifo.sv
// AXI-Stream FIFO with fully registered outputs and a prefetch stage.
// Ports: clk_i, arstn_i (sync, low), t*_i upstream, t*_o downstream,
// level_o fill count, almost_full_o when level_o >= AFULL_LVL.
module axis_reg_fifo
  import axis_buf_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic                tvalid_i,
  output logic                tready_o,
  input  logic [DATA_W-1:0]   tdata_i,
  input  logic                tlast_i,
  input  logic                tready_i,
  output logic                tvalid_o,
  output logic [DATA_W-1:0]   tdata_o,
  output logic                tlast_o,
  output logic [clog2(DEPTH):0] level_o,
  output logic                almost_full_o
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              tvalid_q, tvalid_d;
  logic              tready_q, tready_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic              afull_q, afull_d;

  logic              push, pop, load;
  logic [LW-1:0]     mem_cnt;
  logic [DATA_W:0]   rdata;

  axis_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({tlast_i, tdata_i}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  always_comb begin
    push    = tvalid_i & tready_q;
    pop     = tvalid_q & tready_i;
    // Level counts the output stage too; the array holds the rest.
    mem_cnt = level_q - LW'(tvalid_q);
    // Refill the output stage whenever it is empty or being drained.
    load    = (mem_cnt != '0) & (~tvalid_q | pop);

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(load);
    level_d  = level_q + LW'(push) - LW'(pop);

    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = rdata[DATA_W-1:0];
      tlast_d  = rdata[DATA_W];
    end else if (pop) begin
      tvalid_d = 1'b0;
    end

    tready_d = level_d < LW'(DEPTH);
    afull_d  = level_d >= LW'(AFULL_LVL);
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      tvalid_q <= 1'b0;
      tready_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      tvalid_q <= tvalid_d;
      tready_q <= tready_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      afull_q  <= afull_d;
    end
  end

  assign tready_o      = tready_q;
  assign tvalid_o      = tvalid_q;
  assign tdata_o       = tdata_q;
  assign tlast_o       = tlast_q;
  assign level_o       = level_q;
  assign almost_full_o = afull_q;

endmodule

// File: tb/tb_axis_reg_fifo.sv
// Scoreboard bench for axis_reg_fifo.
// Instance a: defaults (4b, depth 4); instance b: 8b, depth 8.
module tb_axis_reg_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic       a_rstn, a_tvalid_i, a_tlast_i, a_tready_i;
  logic [3:0] a_tdata_i;
  logic       a_tready_o, a_tvalid_o, a_tlast_o, a_afull;
  logic [3:0] a_tdata_o;
  logic [2:0] a_level_o;

  logic       b_rstn, b_tvalid_i, b_tlast_i, b_tready_i;
  logic [7:0] b_tdata_i;
  logic       b_tready_o, b_tvalid_o, b_tlast_o, b_afull;
  logic [7:0] b_tdata_o;
  logic [3:0] b_level_o;

  logic [4:0] qa[$];
  logic [8:0] qb[$];

  axis_reg_fifo u_a (
    .clk_i         (clk),
    .arstn_i       (a_rstn),
    .tvalid_i      (a_tvalid_i),
    .tready_o      (a_tready_o),
    .tdata_i       (a_tdata_i),
    .tlast_i       (a_tlast_i),
    .tready_i      (a_tready_i),
    .tvalid_o      (a_tvalid_o),
    .tdata_o       (a_tdata_o),
    .tlast_o       (a_tlast_o),
    .level_o       (a_level_o),
    .almost_full_o (a_afull)
  );

  axis_reg_fifo #(.DATA_W(8), .DEPTH(8)) u_b (
    .clk_i         (clk),
    .arstn_i       (b_rstn),
    .tvalid_i      (b_tvalid_i),
    .tready_o      (b_tready_o),
    .tdata_i       (b_tdata_i),
    .tlast_i       (b_tlast_i),
    .tready_i      (b_tready_i),
    .tvalid_o      (b_tvalid_o),
    .tdata_o       (b_tdata_o),
    .tlast_o       (b_tlast_o),
    .level_o       (b_level_o),
    .almost_full_o (b_afull)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves tvalid_i high; caller decides when to drop it.
  task automatic send_a(input logic [3:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    a_tdata_i  = d;
    a_tlast_i  = l;
    a_tvalid_i = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = a_tready_o;
      step();
    end
    if (ok) qa.push_back({l, d});
    else chk("a_send_timeout", 0, 1);
  endtask

  task automatic drain_a();
    int k;
    a_tready_i = 1'b1;
    k = 0;
    while (k < 40 && (a_level_o != 0 || a_tvalid_o)) begin
      step();
      k++;
    end
    chk("a_drain_level", a_level_o, 0);
    chk("a_drain_queue", qa.size(), 0);
  endtask

  // Output monitor for instance a.
  always @(negedge clk) begin
    logic [4:0] e;
    if (a_rstn && a_tvalid_o && a_tready_i) begin
      if (qa.size() == 0) chk("a_out_unexpected", {a_tlast_o, a_tdata_o}, 'hx);
      else begin
        e = qa.pop_front();
        chk("a_out", {a_tlast_o, a_tdata_o}, e);
      end
    end
  end

  // Output monitor for instance b, plus hold-stability checks.
  logic       b_hold = 1'b0;
  logic [8:0] b_prev = '0;
  always @(negedge clk) begin
    logic [8:0] e;
    if (b_rstn) begin
      if (b_hold) begin
        chk("b_hold_valid", b_tvalid_o, 1);
        chk("b_hold_data", {b_tlast_o, b_tdata_o}, b_prev);
      end
      if (b_tvalid_o && b_tready_i) begin
        if (qb.size() == 0) chk("b_out_unexpected", {b_tlast_o, b_tdata_o}, 'hx);
        else begin
          e = qb.pop_front();
          chk("b_out", {b_tlast_o, b_tdata_o}, e);
        end
      end
      b_hold = b_tvalid_o && !b_tready_i;
      b_prev = {b_tlast_o, b_tdata_o};
    end else begin
      b_hold = 1'b0;
    end
  end

  initial begin
    int sent;
    bit acc;
    a_rstn = 0; a_tvalid_i = 0; a_tdata_i = 0; a_tlast_i = 0; a_tready_i = 0;
    b_rstn = 0; b_tvalid_i = 0; b_tdata_i = 0; b_tlast_i = 0; b_tready_i = 0;
    step();
    step();

    // Reset state
    chk("rst_tready", a_tready_o, 0);
    chk("rst_tvalid", a_tvalid_o, 0);
    chk("rst_tdata", a_tdata_o, 0);
    chk("rst_tlast", a_tlast_o, 0);
    chk("rst_level", a_level_o, 0);
    chk("rst_afull", a_afull, 0);
    a_rstn = 1;
    b_rstn = 1;
    step();
    chk("rel_tready", a_tready_o, 1);

    // Single word, one-cycle latency
    a_tready_i = 1;
    send_a(4'h3, 1'b1);
    a_tvalid_i = 0;
    chk("one_level1", a_level_o, 1);
    chk("one_tvalid0", a_tvalid_o, 0);
    step();
    chk("one_tvalid", a_tvalid_o, 1);
    chk("one_tdata", a_tdata_o, 3);
    chk("one_tlast", a_tlast_o, 1);
    step();
    chk("one_level0", a_level_o, 0);
    chk("one_empty", a_tvalid_o, 0);
    chk("one_keep", a_tdata_o, 3);

    // Fill to full with downstream stalled
    a_tready_i = 0;
    send_a(4'h1, 0);
    chk("fill_lvl1", a_level_o, 1);
    send_a(4'h2, 0);
    chk("fill_lvl2", a_level_o, 2);
    chk("fill_af2", a_afull, 0);
    send_a(4'h3, 0);
    chk("fill_lvl3", a_level_o, 3);
    chk("fill_af3", a_afull, 1);
    send_a(4'h4, 1);
    chk("full_lvl", a_level_o, 4);
    chk("full_rdy", a_tready_o, 0);
    chk("full_af", a_afull, 1);
    a_tdata_i = 4'h5;
    a_tlast_i = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_hold_lvl", a_level_o, 4);
      chk("full_hold_rdy", a_tready_o, 0);
    end
    a_tvalid_i = 0;

    // Single pop from full
    a_tready_i = 1;
    step();
    a_tready_i = 0;
    chk("pop_lvl", a_level_o, 3);
    chk("pop_rdy", a_tready_o, 1);
    chk("pop_tvalid", a_tvalid_o, 1);
    chk("pop_tdata", a_tdata_o, 2);
    drain_a();

    // Continuous streaming across pointer wrap
    a_tready_i = 1;
    for (int i = 0; i < 20; i++) begin
      if (i >= 2) begin
        chk("strm_tvalid", a_tvalid_o, 1);
        chk("strm_level", a_level_o, 2);
      end
      send_a(4'(i), i == 19);
    end
    a_tvalid_i = 0;
    drain_a();

    // Reset with three words stored
    a_tready_i = 0;
    send_a(4'h7, 0);
    send_a(4'h8, 0);
    send_a(4'h9, 1);
    a_tvalid_i = 0;
    chk("mrst_pre_lvl", a_level_o, 3);
    a_rstn = 0;
    a_tready_i = 1;
    step();
    chk("mrst_tvalid", a_tvalid_o, 0);
    chk("mrst_level", a_level_o, 0);
    chk("mrst_tready", a_tready_o, 0);
    qa.delete();
    a_rstn = 1;
    step();
    chk("mrst_rel_rdy", a_tready_o, 1);
    send_a(4'hA, 1);
    a_tvalid_i = 0;
    drain_a();

    // Random traffic on the 8x8 instance
    sent = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      if (!b_tvalid_i && $urandom_range(1) == 1) begin
        b_tvalid_i = 1;
        b_tdata_i  = 8'($urandom);
        b_tlast_i  = 1'($urandom);
      end
      b_tready_i = 1'($urandom_range(1));
      @(negedge clk);
      acc = b_tvalid_i && b_tready_o;
      step();
      if (acc) begin
        qb.push_back({b_tlast_i, b_tdata_i});
        sent++;
        b_tvalid_i = 0;
      end
    end
    chk("b_sent", sent, 1000);
    b_tvalid_i = 0;
    b_tready_i = 1;
    for (int k = 0; k < 40 && (b_level_o != 0 || b_tvalid_o); k++) step();
    chk("b_drain_level", b_level_o, 0);
    chk("b_drain_queue", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
